// File: rtl/md_sched_pkg.sv
// Shared opcode, state encodings and opcode-class decode for the MD scheduler.
// The MD_MADD_EN macro adds madd/maddu/msub/msubu to the multiply class.
package md_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    localparam logic [3:0] MD_MULT  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_DIV   = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_MTHI  = 4'd4;
    localparam logic [3:0] MD_MTLO  = 4'd5;
    localparam logic [3:0] MD_MADD  = 4'd6;
    localparam logic [3:0] MD_MADDU = 4'd7;
    localparam logic [3:0] MD_MSUB  = 4'd8;
    localparam logic [3:0] MD_MSUBU = 4'd9;

    function automatic logic md_is_mul(input logic [3:0] op);
        case (op)
            MD_MULT, MD_MULTU: return 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_timer.sv
// Loadable 4-bit down-counter; done is high while the count sits at 1,
// marking the last busy cycle of an MD operation.
module md_timer (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic       done_o
);

    logic [3:0] count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= 4'd0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != 4'd0) begin
            count_q <= count_q - 4'd1;
        end
    end

    assign done_o = (count_q == 4'd1);

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: holds HI/LO, models fixed MD latency and stalls D.
// Define MD_MADD_EN to accept madd/maddu/msub/msubu (multiply latency, 64-bit wrap).
module md_sched
    import md_sched_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic        cancel,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MUL_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

    md_state_e   state_q;
    logic [31:0] a_q, b_q, hi_q, lo_q;
    logic [3:0]  op_q;

    logic        issue, issue_mul, issue_div, timer_done, commit_ok;
    logic [63:0] sa, sb, prod_s, prod_u, acc, result_d;
    logic [31:0] qu, ru, mag_a, mag_b, qm, rm, qs, rs;

    assign issue     = start & ~cancel & (state_q == ST_IDLE);
    assign issue_mul = issue & md_is_mul(op);
    assign issue_div = issue & md_is_div(op);

    md_timer u_timer (
        .clk_i      (clk),
        .rst_n_i    (reset),
        .load_i     (issue_mul | issue_div),
        .load_val_i (issue_div ? DIV_N : MUL_N),
        .done_o     (timer_done)
    );

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps instead of trapping.
    always_comb begin
        sa     = {{32{a_q[31]}}, a_q};
        sb     = {{32{b_q[31]}}, b_q};
        prod_s = sa * sb;
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        acc    = {hi_q, lo_q};
        qu     = a_q / b_q;
        ru     = a_q % b_q;
        mag_a  = a_q[31] ? -a_q : a_q;
        mag_b  = b_q[31] ? -b_q : b_q;
        qm     = mag_a / mag_b;
        rm     = mag_a % mag_b;
        qs     = (a_q[31] ^ b_q[31]) ? -qm : qm;
        rs     = a_q[31] ? -rm : rm;
        result_d = acc;
        case (op_q)
            MD_MULT:  result_d = prod_s;
            MD_MULTU: result_d = prod_u;
            MD_DIV:   result_d = {rs, qs};
            MD_DIVU:  result_d = {ru, qu};
`ifdef MD_MADD_EN
            MD_MADD:  result_d = acc + prod_s;
            MD_MADDU: result_d = acc + prod_u;
            MD_MSUB:  result_d = acc - prod_s;
            MD_MSUBU: result_d = acc - prod_u;
`endif
            default:  result_d = acc;
        endcase
    end

    assign commit_ok = ~((state_q == ST_DIV) && (b_q == 32'd0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue_mul | issue_div) begin
                        a_q  <= rs_val;
                        b_q  <= rt_val;
                        op_q <= op;
                    end
                    if (issue_mul)      state_q <= ST_MUL;
                    else if (issue_div) state_q <= ST_DIV;
                    if (issue && op == MD_MTHI) hi_q <= rs_val;
                    if (issue && op == MD_MTLO) lo_q <= rs_val;
                end
                ST_MUL, ST_DIV: begin
                    if (timer_done) begin
                        state_q <= ST_IDLE;
                        if (commit_ok) begin
                            hi_q <= result_d[63:32];
                            lo_q <= result_d[31:0];
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign stall_md = d_is_md & (busy | (start & ~cancel & (md_is_mul(op) | md_is_div(op))));
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: directed vector table, random traffic against a reference model,
// and an asynchronous reset taken mid-multiply.
module tb_md_sched;
    import md_sched_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk, reset, start, cancel, d_is_md;
    logic [3:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, stall_md;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
        .rs_val(rs_val), .rt_val(rt_val), .d_is_md(d_is_md),
        .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // Issuing while busy is illegal in the surrounding pipeline.
    always @(posedge clk) begin
        if (reset === 1'b1 && start === 1'b1 && cancel === 1'b0 && busy === 1'b1) begin
            errors++;
            $display("FAIL start_while_busy op=%0d", op);
        end
    end

    // Reference model: remaining busy cycles plus the pending HI:LO value.
    int          m_left;
    bit          m_pend;
    logic [63:0] m_res;
    logic [31:0] m_hi, m_lo;

    function automatic bit is_muldiv(input logic [3:0] o);
        if (o == MD_MULT || o == MD_MULTU || o == MD_DIV || o == MD_DIVU) return 1'b1;
`ifdef MD_MADD_EN
        if (o == MD_MADD || o == MD_MADDU || o == MD_MSUB || o == MD_MSUBU) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic void model_reset();
        m_left = 0; m_pend = 1'b0; m_res = 64'd0; m_hi = 32'd0; m_lo = 32'd0;
    endfunction

    function automatic void model_edge(input bit st, input logic [3:0] o, input bit c,
                                       input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        acc = {m_hi, m_lo};
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pend) begin
                m_hi = m_res[63:32];
                m_lo = m_res[31:0];
            end
        end else if (st && !c) begin
            case (o)
                MD_MULT:  begin m_res = 64'(sa * sb); m_left = MC; m_pend = 1'b1; end
                MD_MULTU: begin m_res = ua * ub;      m_left = MC; m_pend = 1'b1; end
                MD_DIV: begin
                    m_left = DC; m_pend = (b != 0);
                    if (b != 0) begin
                        q = sa / sb; r = sa % sb;
                        m_res = {r[31:0], q[31:0]};
                    end
                end
                MD_DIVU: begin
                    m_left = DC; m_pend = (b != 0);
                    if (b != 0) m_res = {32'(ua % ub), 32'(ua / ub)};
                end
                MD_MTHI: m_hi = a;
                MD_MTLO: m_lo = a;
`ifdef MD_MADD_EN
                MD_MADD:  begin m_res = acc + 64'(sa * sb); m_left = MC; m_pend = 1'b1; end
                MD_MADDU: begin m_res = acc + ua * ub;      m_left = MC; m_pend = 1'b1; end
                MD_MSUB:  begin m_res = acc - 64'(sa * sb); m_left = MC; m_pend = 1'b1; end
                MD_MSUBU: begin m_res = acc - ua * ub;      m_left = MC; m_pend = 1'b1; end
`endif
                default: ;
            endcase
        end
    endfunction

    logic        a_b, a_s, e_b, e_s;
    logic [31:0] a_h, a_l, e_h, e_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, sample outputs and model expectation at negedge, advance model at posedge.
    task automatic cycle(input bit st, input logic [3:0] o, input bit c,
                         input logic [31:0] a, input logic [31:0] b, input bit dm);
        start = st; op = o; cancel = c; rs_val = a; rt_val = b; d_is_md = dm;
        @(negedge clk);
        a_b = busy; a_s = stall_md; a_h = hi; a_l = lo;
        e_b = (m_left > 0);
        e_s = dm && ((m_left > 0) || (st && !c && is_muldiv(o)));
        e_h = m_hi; e_l = m_lo;
        @(posedge clk);
        model_edge(st, o, c, a, b);
        #1;
    endtask

    typedef struct {
        bit          st;
        logic [3:0]  op;
        bit          can;
        logic [31:0] rs;
        logic [31:0] rt;
        bit          dm;
        bit          eb;
        bit          es;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit st, input logic [3:0] o, input bit c, input logic [31:0] a,
                       input logic [31:0] b, input bit dm, input bit eb, input bit es,
                       input logic [31:0] eh, input logic [31:0] el, input int n = 1);
        vec_t v;
        v.st = st; v.op = o; v.can = c; v.rs = a; v.rt = b; v.dm = dm;
        v.eb = eb; v.es = es; v.eh = eh; v.el = el;
        repeat (n) tbl.push_back(v);
    endtask

    initial begin
        // Directed vectors: inputs held for one cycle, expected outputs seen in that cycle.
        add(1, MD_MTHI, 0, 32'h12345678, 0, 0, 0, 0, 32'h0, 32'h0);
        add(0, 4'd0, 0, 0, 0, 0, 0, 0, 32'h12345678, 32'h0);
        add(1, MD_DIV, 1, 32'd5, 32'd1, 1, 0, 0, 32'h12345678, 32'h0);
        add(0, 4'd0, 0, 0, 0, 1, 0, 0, 32'h12345678, 32'h0);
        add(1, MD_MULT, 0, 32'hFFFFFFFF, 32'd2, 1, 0, 1, 32'h12345678, 32'h0);
        add(0, 4'd0, 0, 0, 0, 1, 1, 1, 32'h12345678, 32'h0, MC);
        add(0, 4'd0, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE);
        add(1, MD_MULTU, 0, 32'hFFFFFFFF, 32'd2, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE);
        add(0, 4'd0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, MC);
        add(1, MD_DIV, 0, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 32'h00000001, 32'hFFFFFFFE);
        add(0, 4'd0, 0, 0, 0, 0, 1, 0, 32'h00000001, 32'hFFFFFFFE, DC);
        add(1, MD_DIVU, 0, 32'h1234, 32'd0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        add(0, 4'd0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, DC);
        add(1, MD_MULT, 0, 32'd3, 32'd4, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        add(0, 4'd0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, MC);
        add(1, MD_MTHI, 0, 32'd0, 0, 0, 0, 0, 32'h0, 32'h0000000C);
        add(1, MD_MTLO, 0, 32'd1, 0, 0, 0, 0, 32'h0, 32'h0000000C);
        add(1, MD_MADD, 0, 32'd3, 32'd4, 0, 0, 0, 32'h0, 32'h00000001);
`ifdef MD_MADD_EN
        add(0, 4'd0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h00000001, MC);
        add(0, 4'd0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0000000D);
        add(1, 4'hF, 0, 32'd9, 32'd9, 1, 0, 0, 32'h0, 32'h0000000D);
        add(0, 4'd0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0000000D);
`else
        add(0, 4'd0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h00000001, 2);
        add(1, 4'hF, 0, 32'd9, 32'd9, 1, 0, 0, 32'h0, 32'h00000001);
        add(0, 4'd0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h00000001);
`endif

        reset = 1'b0; start = 1'b0; op = 4'd0; cancel = 1'b0;
        rs_val = 32'd0; rt_val = 32'd0; d_is_md = 1'b0;
        model_reset();
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_stall", {31'd0, stall_md}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].st, tbl[i].op, tbl[i].can, tbl[i].rs, tbl[i].rt, tbl[i].dm);
            chk($sformatf("vec%0d_busy", i), {31'd0, a_b}, {31'd0, tbl[i].eb});
            chk($sformatf("vec%0d_stall", i), {31'd0, a_s}, {31'd0, tbl[i].es});
            chk($sformatf("vec%0d_hi", i), a_h, tbl[i].eh);
            chk($sformatf("vec%0d_lo", i), a_l, tbl[i].el);
        end

        // Cancel arriving while a divide is in flight must not abort it.
        cycle(1, MD_DIV, 0, 32'd100, 32'd7, 1);
        for (int i = 0; i < DC + 2; i++) begin
            cycle(0, 4'd0, 1, 0, 0, 1);
            chk("cancel_busy", {31'd0, a_b}, {31'd0, e_b});
            chk("cancel_stall", {31'd0, a_s}, {31'd0, e_s});
            chk("cancel_hi", a_h, e_h);
            chk("cancel_lo", a_l, e_l);
        end
        chk("cancel_div_lo", a_l, 32'd14);
        chk("cancel_div_hi", a_h, 32'd2);

        // Random traffic; issues only while the model says the unit is idle.
        for (int i = 0; i < 600; i++) begin
            bit          st, c, dm;
            logic [3:0]  o;
            logic [31:0] a, b;
            st = (m_left == 0) && ($urandom_range(0, 2) != 0);
            c  = ($urandom_range(0, 3) == 0);
            dm = $urandom_range(0, 1) != 0;
            o  = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            if ($urandom_range(0, 31) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            cycle(st, o, c, a, b, dm);
            chk("rand_busy", {31'd0, a_b}, {31'd0, e_b});
            chk("rand_stall", {31'd0, a_s}, {31'd0, e_s});
            chk("rand_hi", a_h, e_h);
            chk("rand_lo", a_l, e_l);
        end
        while (m_left > 0) cycle(0, 4'd0, 0, 0, 0, 0);

        // Asynchronous reset with three busy cycles left in a multiply.
        cycle(1, MD_MTHI, 0, 32'hDEAD0000, 0, 0);
        cycle(1, MD_MTLO, 0, 32'h0000BEEF, 0, 0);
        cycle(1, MD_MULT, 0, 32'd7, 32'd7, 0);
        cycle(0, 4'd0, 0, 0, 0, 0);
        cycle(0, 4'd0, 0, 0, 0, 0);
        chk("prereset_busy", {31'd0, busy}, 32'd1);
        chk("prereset_hi", hi, 32'hDEAD0000);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        chk("async_reset_hi", hi, 32'd0);
        chk("async_reset_lo", lo, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < MC + 2; i++) begin
            cycle(0, 4'd0, 0, 0, 0, 1);
            chk("post_reset_busy", {31'd0, a_b}, 32'd0);
            chk("post_reset_stall", {31'd0, a_s}, 32'd0);
            chk("post_reset_lo", a_l, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
